// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for seg7_scan_ctrl: value/dp load and enable in, segment/anode drive and frame pulse out.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en_i;
    logic                      load_i;
    logic [4*NUM_DIGITS-1:0]   value_i;
    logic [NUM_DIGITS-1:0]     dp_i;
    logic [6:0]                seg_o;
    logic                      dp_o;
    logic [NUM_DIGITS-1:0]     an_o;
    logic                      frame_o;

    modport master (
        output en_i, load_i, value_i, dp_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  en_i, load_i, value_i, dp_i,
        output seg_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with frame-synchronous double-buffered value updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int REFRESH_HZ  = 1_000
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int DIV = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("seg7_scan_ctrl: scan divider must be at least 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
        $error("seg7_scan_ctrl: NUM_DIGITS must be 1..8");
    end

    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] pending_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic                    pend_valid_reg;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic [NUM_DIGITS-1:0]   disp_dp_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_reg;

    logic                    tick;
    logic                    fb;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nib;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick = (presc_reg == PRESC_MAX);
    assign fb   = tick && (idx_reg == IDX_MAX);

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero only if it and every more-significant digit have zero nibble and no dp.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi] = ~(|{display_reg[4*NUM_DIGITS-1:4*gi], disp_dp_reg[NUM_DIGITS-1:gi]});
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        nib      = display_reg[{idx_reg, 2'b00} +: 4];
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (bus.en_i) begin
            an_next[idx_reg] = blank[idx_reg];
            seg_next         = ~hex7(nib);
            dp_next          = ~disp_dp_reg[idx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg      <= '0;
            idx_reg        <= '0;
            pending_reg    <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            display_reg    <= '0;
            disp_dp_reg    <= '0;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
            frame_reg      <= 1'b0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end
            frame_reg <= fb;
            // A load landing on the boundary goes straight to display and supersedes any pending value.
            if (fb && bus.load_i) begin
                display_reg    <= bus.value_i;
                disp_dp_reg    <= bus.dp_i;
                pend_valid_reg <= 1'b0;
            end else if (fb && pend_valid_reg) begin
                display_reg    <= pending_reg;
                disp_dp_reg    <= pend_dp_reg;
                pend_valid_reg <= 1'b0;
            end else if (bus.load_i) begin
                pending_reg    <= bus.value_i;
                pend_dp_reg    <= bus.dp_i;
                pend_valid_reg <= 1'b1;
            end
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg_o   = seg_reg;
    assign bus.dp_o    = dp_reg;
    assign bus.an_o    = an_reg;
    assign bus.frame_o = frame_reg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, scan divider 4, 16-cycle frame.
module tb_seg7_scan_ctrl;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [27:0] seg;       // expected seg_o per digit, {d3,d2,d1,d0}
        logic [3:0]  dpo;       // expected dp_o per digit
        logic [3:0]  lit_plain; // digits lit without blanking
        logic [3:0]  lit_lz;    // digits lit with leading-zero blanking
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   watch = 1'b0;
    bit   seen_one = 1'b0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .CLK_FREQ_HZ(80),
        .REFRESH_HZ (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch && bus.an_o != 4'hF && bus.seg_o == 7'h79) seen_one <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        bit found = 1'b0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.frame_o) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_o in %0d cycles expected frame_o=1", n);
        end
    endtask

    // Entered on the cycle frame_o is high; digit d is shown from 1+4d to 4+4d cycles later.
    task automatic check_frame(input vec_t v, input string tag);
        logic [3:0] lit;
        logic [3:0] one;
        lit = LZ ? v.lit_lz : v.lit_plain;
        one = 4'b0001;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (4) @(negedge clk);
            check($sformatf("%s_an%0d", tag, d), {28'd0, bus.an_o}, {28'd0, lit[d] ? ~(one << d) : 4'hF});
            check($sformatf("%s_seg%0d", tag, d), {25'd0, bus.seg_o}, {25'd0, v.seg[7*d +: 7]});
            check($sformatf("%s_dp%0d", tag, d), {31'd0, bus.dp_o}, {31'd0, v.dpo[d]});
        end
    endtask

    initial begin
        vec_t tbl [7];
        vec_t v2222;
        vec_t v00c0;
        logic [27:0] prev_seg;

        tbl[0] = '{16'h12AF, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111, 4'hF, 4'hF};
        tbl[1] = '{16'h3456, 4'b1010, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0101, 4'hF, 4'hF};
        tbl[2] = '{16'h789B, 4'b0001, {7'h78, 7'h00, 7'h10, 7'h03}, 4'b1110, 4'hF, 4'hF};
        tbl[3] = '{16'hCDE0, 4'b0000, {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1111, 4'hF, 4'hF};
        tbl[4] = '{16'h0000, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1011, 4'hF, 4'b0111};
        tbl[5] = '{16'h0F00, 4'b0000, {7'h40, 7'h0E, 7'h40, 7'h40}, 4'b1111, 4'hF, 4'b0111};
        tbl[6] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'hF, 4'b0001};
        v2222  = '{16'h2222, 4'b0000, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'hF, 4'hF};
        v00c0  = '{16'h00C0, 4'b0000, {7'h40, 7'h40, 7'h46, 7'h40}, 4'b1111, 4'hF, 4'b0011};

        rst = 1'b1;
        bus.en_i = 1'b1;
        bus.load_i = 1'b0;
        bus.value_i = '0;
        bus.dp_i = '0;

        // Reset state, then the post-reset anode walk across one frame
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, bus.an_o}, 32'hF);
        check("rst_seg", {25'd0, bus.seg_o}, 32'h7F);
        check("rst_dp", {31'd0, bus.dp_o}, 32'h1);
        check("rst_frame", {31'd0, bus.frame_o}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] one;
            logic [3:0] exp_an;
            one = 4'b0001;
            exp_an = (LZ && (k / 4) > 0) ? 4'hF : ~(one << (k / 4));
            @(negedge clk);
            check($sformatf("scan_an_c%0d", k), {28'd0, bus.an_o}, {28'd0, exp_an});
            check($sformatf("scan_frame_c%0d", k), {31'd0, bus.frame_o}, {31'd0, k == 15});
        end

        // Table: mid-frame load held back until the boundary, shown in the following frame
        prev_seg = {4{7'h40}};
        for (int i = 0; i < 7; i++) begin
            wait_frame();
            repeat (3) @(negedge clk);
            bus.value_i = tbl[i].value;
            bus.dp_i = tbl[i].dp;
            bus.load_i = 1'b1;
            @(negedge clk);
            bus.load_i = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_hold_seg1", i), {25'd0, bus.seg_o}, {25'd0, prev_seg[13:7]});
            wait_frame();
            check_frame(tbl[i], $sformatf("v%0d", i));
            prev_seg = tbl[i].seg;
        end

        // Two loads in one frame: only the last is displayed
        watch = 1'b1;
        wait_frame();
        repeat (2) @(negedge clk);
        bus.value_i = 16'h1111;
        bus.dp_i = 4'b0000;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.value_i = 16'h2222;
        @(negedge clk);
        bus.load_i = 1'b0;
        wait_frame();
        check_frame(v2222, "last_wins");
        watch = 1'b0;
        check("never_1111", {31'd0, seen_one}, 32'h0);

        // Display disable mid-frame: outputs off, scanning continues
        wait_frame();
        repeat (3) @(negedge clk);
        bus.en_i = 1'b0;
        @(negedge clk);
        check("dis_an", {28'd0, bus.an_o}, 32'hF);
        check("dis_seg", {25'd0, bus.seg_o}, 32'h7F);
        check("dis_dp", {31'd0, bus.dp_o}, 32'h1);
        repeat (8) @(negedge clk);
        check("dis_an_late", {28'd0, bus.an_o}, 32'hF);
        @(negedge clk);
        bus.en_i = 1'b1;
        @(negedge clk);
        check("resume_an", {28'd0, bus.an_o}, 32'h7);
        check("resume_seg", {25'd0, bus.seg_o}, 32'h24);
        @(negedge clk);
        check("dis_frame_lo", {31'd0, bus.frame_o}, 32'h0);
        @(negedge clk);
        check("dis_frame_period", {31'd0, bus.frame_o}, 32'h1);

        // Pending load overridden by a load on the boundary cycle itself
        repeat (3) @(negedge clk);
        bus.value_i = 16'h5555;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        repeat (11) @(negedge clk);
        bus.value_i = 16'h00C0;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        check("bypass_frame", {31'd0, bus.frame_o}, 32'h1);
        check_frame(v00c0, "bypass");
        wait_frame();
        check_frame(v00c0, "bypass_kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
